// File: rtl/rob_commit_unit.sv
// Reorder buffer: dual dispatch allocation, dual CDB capture, dual in-order retirement to the register file.
// Optional `ROB_FORWARD_EN adds two dispatch-time operand read ports (fwd_tag_* -> fwd_ready_*/fwd_data_*).
module rob_commit_unit #(
  parameter int DW    = 32,
  parameter int TAG_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             alloc_a,
  input  logic             alloc_b,
  input  logic [4:0]       alloc_rd_a,
  input  logic [4:0]       alloc_rd_b,
  output logic             alloc_rdy_a,
  output logic             alloc_rdy_b,
  output logic             wlwta,
  output logic             wlwtb,
  output logic [4:0]       wlwt_wna,
  output logic [4:0]       wlwt_wnb,
  output logic [TAG_W-1:0] wlwt_ROB_index_a,
  output logic [TAG_W-1:0] wlwt_ROB_index_b,
  input  logic             cdb_v_a,
  input  logic             cdb_v_b,
  input  logic [TAG_W-1:0] cdb_tag_a,
  input  logic [TAG_W-1:0] cdb_tag_b,
  input  logic [DW-1:0]    cdb_data_a,
  input  logic [DW-1:0]    cdb_data_b,
  output logic             wea,
  output logic             web,
  output logic [4:0]       wna,
  output logic [4:0]       wnb,
  output logic [TAG_W-1:0] ROB_index_wta,
  output logic [TAG_W-1:0] ROB_index_wtb,
  output logic [DW-1:0]    dataina,
  output logic [DW-1:0]    datainb,
`ifdef ROB_FORWARD_EN
  input  logic [TAG_W-1:0] fwd_tag_a,
  input  logic [TAG_W-1:0] fwd_tag_b,
  output logic             fwd_ready_a,
  output logic             fwd_ready_b,
  output logic [DW-1:0]    fwd_data_a,
  output logic [DW-1:0]    fwd_data_b,
`endif
  output logic [TAG_W-1:0] rob_count
);

  localparam int N = 2 ** TAG_W;
  localparam logic [TAG_W-1:0] LAST = TAG_W'(N - 1);

  // Tag 0 means "no producer", so pointers cycle through 1..LAST only.
  function automatic logic [TAG_W-1:0] ptr_inc(input logic [TAG_W-1:0] p);
    return (p == LAST) ? TAG_W'(1) : p + TAG_W'(1);
  endfunction

  logic [N-1:0]     r_valid;
  logic [N-1:0]     r_done;
  logic [4:0]       r_rd   [N];
  logic [DW-1:0]    r_data [N];
  logic [TAG_W-1:0] r_head;
  logic [TAG_W-1:0] r_tail;
  logic [TAG_W-1:0] r_count;

  logic [N-1:0]     w_valid_next;
  logic [N-1:0]     w_done_next;
  logic [N-1:0]     w_alloc_we;
  logic [N-1:0]     w_wr_a;
  logic [N-1:0]     w_wr_b;
  logic [4:0]       w_alloc_rd [N];

  logic             w_rdy_a;
  logic             w_rdy_b;
  logic             w_acc_a;
  logic             w_acc_b;
  logic [TAG_W-1:0] w_tail_p1;
  logic [TAG_W-1:0] w_tag_b;
  logic [TAG_W-1:0] w_head_p1;
  logic             w_commit_a;
  logic             w_commit_b;
  logic             w_cdb_a;
  logic             w_cdb_b;
  logic [TAG_W-1:0] w_head_next;
  logic [TAG_W-1:0] w_tail_next;
  logic [TAG_W-1:0] w_count_next;

  // Grants look only at the registered count, so entries retiring this cycle are not reused until next cycle.
  assign w_rdy_a   = !flush && (r_count <= TAG_W'(N - 2));
  assign w_rdy_b   = !flush && (r_count <= TAG_W'(N - 3));
  assign w_acc_a   = alloc_a && w_rdy_a;
  assign w_acc_b   = alloc_a && alloc_b && w_rdy_b;
  assign w_tail_p1 = ptr_inc(r_tail);
  assign w_tag_b   = w_acc_a ? w_tail_p1 : r_tail;

  assign w_head_p1  = ptr_inc(r_head);
  assign w_commit_a = !flush && r_valid[r_head] && r_done[r_head];
  assign w_commit_b = w_commit_a && r_valid[w_head_p1] && r_done[w_head_p1];

  assign w_cdb_a = cdb_v_a && !flush;
  assign w_cdb_b = cdb_v_b && !flush;

  assign w_head_next  = w_commit_b ? ptr_inc(w_head_p1) : (w_commit_a ? w_head_p1 : r_head);
  assign w_tail_next  = w_acc_b ? ptr_inc(w_tag_b) : (w_acc_a ? w_tail_p1 : r_tail);
  assign w_count_next = r_count + TAG_W'(w_acc_a) + TAG_W'(w_acc_b)
                      - TAG_W'(w_commit_a) - TAG_W'(w_commit_b);

  genvar gi;
  generate
    for (gi = 0; gi < N; gi++) begin : g_entry
      if (gi == 0) begin : g_null
        assign w_valid_next[gi] = 1'b0;
        assign w_done_next[gi]  = 1'b0;
        assign w_alloc_we[gi]   = 1'b0;
        assign w_wr_a[gi]       = 1'b0;
        assign w_wr_b[gi]       = 1'b0;
        assign w_alloc_rd[gi]   = 5'd0;
      end else begin : g_live
        logic w_hit_a;
        logic w_hit_b;
        logic w_hit_commit;
        assign w_hit_a      = w_acc_a && (r_tail == TAG_W'(gi));
        assign w_hit_b      = w_acc_b && (w_tag_b == TAG_W'(gi));
        assign w_hit_commit = (w_commit_a && (r_head == TAG_W'(gi)))
                           || (w_commit_b && (w_head_p1 == TAG_W'(gi)));
        assign w_wr_a[gi]     = w_cdb_a && (cdb_tag_a == TAG_W'(gi)) && r_valid[gi];
        assign w_wr_b[gi]     = w_cdb_b && (cdb_tag_b == TAG_W'(gi)) && r_valid[gi];
        assign w_alloc_we[gi] = w_hit_a || w_hit_b;
        assign w_alloc_rd[gi] = w_hit_a ? alloc_rd_a : alloc_rd_b;
        assign w_valid_next[gi] = flush ? 1'b0 :
                                  w_alloc_we[gi] ? 1'b1 :
                                  w_hit_commit ? 1'b0 : r_valid[gi];
        assign w_done_next[gi]  = flush ? 1'b0 :
                                  (w_alloc_we[gi] || w_hit_commit) ? 1'b0 :
                                  (r_done[gi] || w_wr_a[gi] || w_wr_b[gi]);
      end
    end
  endgenerate

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_valid <= '0;
      r_done  <= '0;
      r_head  <= TAG_W'(1);
      r_tail  <= TAG_W'(1);
      r_count <= '0;
    end else begin
      r_valid <= w_valid_next;
      r_done  <= w_done_next;
      if (flush) begin
        r_head  <= TAG_W'(1);
        r_tail  <= TAG_W'(1);
        r_count <= '0;
      end else begin
        r_head  <= w_head_next;
        r_tail  <= w_tail_next;
        r_count <= w_count_next;
      end
    end
  end

  // Payload needs no reset: it is only observed through valid/done-qualified paths.
  always_ff @(posedge clk) begin
    for (int i = 0; i < N; i++) begin
      if (w_alloc_we[i]) r_rd[i] <= w_alloc_rd[i];
      if (w_wr_b[i]) r_data[i] <= cdb_data_b;
      else if (w_wr_a[i]) r_data[i] <= cdb_data_a;
    end
  end

  assign alloc_rdy_a      = w_rdy_a;
  assign alloc_rdy_b      = w_rdy_b;
  assign wlwta            = w_acc_a && (alloc_rd_a != 5'd0);
  assign wlwtb            = w_acc_b && (alloc_rd_b != 5'd0);
  assign wlwt_wna         = w_acc_a ? alloc_rd_a : 5'd0;
  assign wlwt_wnb         = w_acc_b ? alloc_rd_b : 5'd0;
  assign wlwt_ROB_index_a = w_acc_a ? r_tail : '0;
  assign wlwt_ROB_index_b = w_acc_b ? w_tag_b : '0;

  assign wea           = w_commit_a && (r_rd[r_head] != 5'd0);
  assign web           = w_commit_b && (r_rd[w_head_p1] != 5'd0);
  assign wna           = w_commit_a ? r_rd[r_head] : 5'd0;
  assign wnb           = w_commit_b ? r_rd[w_head_p1] : 5'd0;
  assign ROB_index_wta = w_commit_a ? r_head : '0;
  assign ROB_index_wtb = w_commit_b ? w_head_p1 : '0;
  assign dataina       = w_commit_a ? r_data[r_head] : '0;
  assign datainb       = w_commit_b ? r_data[w_head_p1] : '0;
  assign rob_count     = r_count;

`ifdef ROB_FORWARD_EN
  // Entry 0 is never valid, so a tag-0 lookup naturally reports not ready.
  assign fwd_ready_a = r_valid[fwd_tag_a] && r_done[fwd_tag_a];
  assign fwd_ready_b = r_valid[fwd_tag_b] && r_done[fwd_tag_b];
  assign fwd_data_a  = fwd_ready_a ? r_data[fwd_tag_a] : '0;
  assign fwd_data_b  = fwd_ready_b ? r_data[fwd_tag_b] : '0;
`endif

endmodule

// File: tb/tb_rob_commit_unit.sv
// Bench for rob_commit_unit: queue-based program-order model checked every cycle, plus directed literal checks.
module tb_rob_commit_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush;
  logic        alloc_a, alloc_b;
  logic [4:0]  alloc_rd_a, alloc_rd_b;
  logic        alloc_rdy_a, alloc_rdy_b;
  logic        wlwta, wlwtb;
  logic [4:0]  wlwt_wna, wlwt_wnb;
  logic [3:0]  wlwt_ROB_index_a, wlwt_ROB_index_b;
  logic        cdb_v_a, cdb_v_b;
  logic [3:0]  cdb_tag_a, cdb_tag_b;
  logic [31:0] cdb_data_a, cdb_data_b;
  logic        wea, web;
  logic [4:0]  wna, wnb;
  logic [3:0]  ROB_index_wta, ROB_index_wtb;
  logic [31:0] dataina, datainb;
  logic [3:0]  rob_count;
  logic [3:0]  fwd_tag_a, fwd_tag_b;
`ifdef ROB_FORWARD_EN
  logic        fwd_ready_a, fwd_ready_b;
  logic [31:0] fwd_data_a, fwd_data_b;
`endif

  int n_checks = 0;
  int n_err = 0;

  rob_commit_unit #(.DW(32), .TAG_W(4)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .alloc_a(alloc_a), .alloc_b(alloc_b),
    .alloc_rd_a(alloc_rd_a), .alloc_rd_b(alloc_rd_b),
    .alloc_rdy_a(alloc_rdy_a), .alloc_rdy_b(alloc_rdy_b),
    .wlwta(wlwta), .wlwtb(wlwtb),
    .wlwt_wna(wlwt_wna), .wlwt_wnb(wlwt_wnb),
    .wlwt_ROB_index_a(wlwt_ROB_index_a), .wlwt_ROB_index_b(wlwt_ROB_index_b),
    .cdb_v_a(cdb_v_a), .cdb_v_b(cdb_v_b),
    .cdb_tag_a(cdb_tag_a), .cdb_tag_b(cdb_tag_b),
    .cdb_data_a(cdb_data_a), .cdb_data_b(cdb_data_b),
    .wea(wea), .web(web), .wna(wna), .wnb(wnb),
    .ROB_index_wta(ROB_index_wta), .ROB_index_wtb(ROB_index_wtb),
    .dataina(dataina), .datainb(datainb),
`ifdef ROB_FORWARD_EN
    .fwd_tag_a(fwd_tag_a), .fwd_tag_b(fwd_tag_b),
    .fwd_ready_a(fwd_ready_a), .fwd_ready_b(fwd_ready_b),
    .fwd_data_a(fwd_data_a), .fwd_data_b(fwd_data_b),
`endif
    .rob_count(rob_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s actual=0x%0h expected=0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: the ROB as a program-ordered queue of in-flight instructions.
  typedef struct {
    logic [3:0]  tag;
    logic [4:0]  rd;
    bit          done;
    logic [31:0] data;
  } ent_t;

  ent_t       m_q[$];
  logic [3:0] m_tail = 4'd1;

  function automatic logic [3:0] nxt(input logic [3:0] t);
    return (t == 4'd15) ? 4'd1 : t + 4'd1;
  endfunction

  function automatic bit m_ready(input logic [3:0] t);
    foreach (m_q[k]) if (m_q[k].tag == t && m_q[k].done) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic [31:0] m_data(input logic [3:0] t);
    foreach (m_q[k]) if (m_q[k].tag == t && m_q[k].done) return m_q[k].data;
    return 32'd0;
  endfunction

  always @(negedge clk) begin : compare
    int n;
    bit ra, rb, aa, ab, ca, cb;
    logic [3:0] ta, tbb;
    ent_t e;
    if (rst) begin
      m_q.delete();
      m_tail = 4'd1;
      chk("rst_count", rob_count, 0);
      chk("rst_rdy_a", alloc_rdy_a, 1);
      chk("rst_rdy_b", alloc_rdy_b, 1);
      chk("rst_wlwta", wlwta, 0);
      chk("rst_wlwtb", wlwtb, 0);
      chk("rst_idx_a", wlwt_ROB_index_a, 0);
      chk("rst_wea", wea, 0);
      chk("rst_web", web, 0);
      chk("rst_wta", ROB_index_wta, 0);
      chk("rst_dataina", dataina, 0);
    end else begin
      n  = m_q.size();
      ra = !flush && n <= 14;
      rb = !flush && n <= 13;
      aa = alloc_a && ra;
      ab = alloc_a && alloc_b && rb;
      ta = m_tail;
      tbb = aa ? nxt(m_tail) : m_tail;
      ca = 0; cb = 0;
      if (!flush && n >= 1) ca = m_q[0].done;
      if (ca && n >= 2) cb = m_q[1].done;

      chk("m_count", rob_count, n);
      chk("m_rdy_a", alloc_rdy_a, ra);
      chk("m_rdy_b", alloc_rdy_b, rb);
      chk("m_wlwta", wlwta, aa && alloc_rd_a != 0);
      chk("m_wlwtb", wlwtb, ab && alloc_rd_b != 0);
      chk("m_wlwt_wna", wlwt_wna, aa ? alloc_rd_a : 5'd0);
      chk("m_wlwt_wnb", wlwt_wnb, ab ? alloc_rd_b : 5'd0);
      chk("m_idx_a", wlwt_ROB_index_a, aa ? ta : 4'd0);
      chk("m_idx_b", wlwt_ROB_index_b, ab ? tbb : 4'd0);
      chk("m_wea", wea, ca && m_q[0].rd != 0);
      chk("m_wna", wna, ca ? m_q[0].rd : 5'd0);
      chk("m_wta", ROB_index_wta, ca ? m_q[0].tag : 4'd0);
      chk("m_dataina", dataina, ca ? m_q[0].data : 32'd0);
      chk("m_web", web, cb && m_q[1].rd != 0);
      chk("m_wnb", wnb, cb ? m_q[1].rd : 5'd0);
      chk("m_wtb", ROB_index_wtb, cb ? m_q[1].tag : 4'd0);
      chk("m_datainb", datainb, cb ? m_q[1].data : 32'd0);
`ifdef ROB_FORWARD_EN
      chk("m_fwd_ready_a", fwd_ready_a, fwd_tag_a != 0 && m_ready(fwd_tag_a));
      chk("m_fwd_ready_b", fwd_ready_b, fwd_tag_b != 0 && m_ready(fwd_tag_b));
      chk("m_fwd_data_a", fwd_data_a, m_data(fwd_tag_a));
      chk("m_fwd_data_b", fwd_data_b, m_data(fwd_tag_b));
`endif

      if (flush) begin
        m_q.delete();
        m_tail = 4'd1;
      end else begin
        if (cdb_v_a) foreach (m_q[k]) if (m_q[k].tag == cdb_tag_a) begin
          m_q[k].done = 1; m_q[k].data = cdb_data_a;
        end
        if (cdb_v_b) foreach (m_q[k]) if (m_q[k].tag == cdb_tag_b) begin
          m_q[k].done = 1; m_q[k].data = cdb_data_b;
        end
        if (ca) void'(m_q.pop_front());
        if (cb) void'(m_q.pop_front());
        if (aa) begin
          e.tag = m_tail; e.rd = alloc_rd_a; e.done = 0; e.data = 0;
          m_q.push_back(e);
          m_tail = nxt(m_tail);
        end
        if (ab) begin
          e.tag = m_tail; e.rd = alloc_rd_b; e.done = 0; e.data = 0;
          m_q.push_back(e);
          m_tail = nxt(m_tail);
        end
      end
    end
  end

  task automatic clr();
    flush = 0; alloc_a = 0; alloc_b = 0; alloc_rd_a = 0; alloc_rd_b = 0;
    cdb_v_a = 0; cdb_v_b = 0; cdb_tag_a = 0; cdb_tag_b = 0;
    cdb_data_a = 0; cdb_data_b = 0; fwd_tag_a = 0; fwd_tag_b = 0;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
    clr();
  endtask

  initial begin
    rst = 1;
    clr();
    repeat (2) @(posedge clk);
    #1 rst = 0;
    #1;
    chk("t0_count", rob_count, 0);
    chk("t0_rdy_a", alloc_rdy_a, 1);

    // Dual allocation gets tags 1 and 2
    alloc_a = 1; alloc_rd_a = 3; alloc_b = 1; alloc_rd_b = 5;
    #1;
    chk("t1_idx_a", wlwt_ROB_index_a, 1);
    chk("t1_idx_b", wlwt_ROB_index_b, 2);
    chk("t1_wlwta", wlwta, 1);
    chk("t1_wlwtb", wlwtb, 1);
    chk("t1_wna", wlwt_wna, 3);
    chk("t1_wnb", wlwt_wnb, 5);
    next_cycle(); #1;
    chk("t1_count", rob_count, 2);

    // Out-of-order completion, in-order dual retirement
    cdb_v_a = 1; cdb_tag_a = 2; cdb_data_a = 32'hBEEF;
    #1 chk("t2_wea_wait1", wea, 0);
    next_cycle(); cdb_v_a = 1; cdb_tag_a = 1; cdb_data_a = 32'h1234;
    #1 chk("t2_wea_wait2", wea, 0);
    next_cycle(); #1;
    chk("t2_wea", wea, 1);
    chk("t2_web", web, 1);
    chk("t2_wna", wna, 3);
    chk("t2_dataina", dataina, 32'h1234);
    chk("t2_wnb", wnb, 5);
    chk("t2_datainb", datainb, 32'hBEEF);
    chk("t2_wtb", ROB_index_wtb, 2);
    next_cycle(); #1;
    chk("t2_count", rob_count, 0);

    // Fill to capacity from tag 1, then wrap back to tag 1
    flush = 1;
    #1 chk("t3_flush_rdy", alloc_rdy_a, 0);
    next_cycle(); #1;
    for (int i = 0; i < 15; i++) begin
      chk("t3_fill_count", rob_count, i);
      chk("t3_fill_rdy_b", alloc_rdy_b, (i <= 13));
      alloc_a = 1; alloc_rd_a = 5'(i + 1);
      #1 chk("t3_fill_idx", wlwt_ROB_index_a, i + 1);
      next_cycle(); #1;
    end
    chk("t3_full_count", rob_count, 15);
    chk("t3_full_rdy_a", alloc_rdy_a, 0);
    chk("t3_full_rdy_b", alloc_rdy_b, 0);
    alloc_a = 1; alloc_rd_a = 2;
    cdb_v_a = 1; cdb_tag_a = 1; cdb_data_a = 32'h11;
    #1 chk("t3_full_wlwta", wlwta, 0);
    next_cycle(); #1;
    chk("t3_commit_wea", wea, 1);
    chk("t3_commit_data", dataina, 32'h11);
    chk("t3_commit_rdy_a", alloc_rdy_a, 0);
    next_cycle(); #1;
    chk("t3_after_rdy_a", alloc_rdy_a, 1);
    chk("t3_after_rdy_b", alloc_rdy_b, 0);
    alloc_a = 1; alloc_rd_a = 9; alloc_b = 1; alloc_rd_b = 4;
    #1;
    chk("t3_wrap_idx", wlwt_ROB_index_a, 1);
    chk("t3_wrap_wlwtb", wlwtb, 0);
    next_cycle(); #1;
    chk("t3_refill_count", rob_count, 15);

    // rd=0 entry at head retires silently, rd=7 behind it retires as slot b
    flush = 1;
    next_cycle();
    alloc_a = 1; alloc_rd_a = 0; alloc_b = 1; alloc_rd_b = 7;
    #1;
    chk("t4_wlwta", wlwta, 0);
    chk("t4_idx_b", wlwt_ROB_index_b, 2);
    next_cycle();
    cdb_v_a = 1; cdb_tag_a = 1; cdb_data_a = 32'h5;
    cdb_v_b = 1; cdb_tag_b = 2; cdb_data_b = 32'h77;
    next_cycle(); #1;
    chk("t4_wea", wea, 0);
    chk("t4_wta", ROB_index_wta, 1);
    chk("t4_web", web, 1);
    chk("t4_wnb", wnb, 7);
    chk("t4_datainb", datainb, 32'h77);
    next_cycle();
    alloc_a = 1; alloc_rd_a = 12;
    next_cycle();
    cdb_v_a = 1; cdb_tag_a = 3; cdb_data_a = 32'hAAAA;
    cdb_v_b = 1; cdb_tag_b = 3; cdb_data_b = 32'hBBBB;
    next_cycle(); #1;
    chk("t4_cdb_b_wins", dataina, 32'hBBBB);
    chk("t4_same_wna", wna, 12);

    // Flush with six entries, two completed at head
    for (int i = 0; i < 3; i++) begin
      next_cycle();
      alloc_a = 1; alloc_rd_a = 5'(2 * i + 1); alloc_b = 1; alloc_rd_b = 5'(2 * i + 2);
    end
    next_cycle();
    cdb_v_a = 1; cdb_tag_a = 4; cdb_data_a = 32'h44;
    cdb_v_b = 1; cdb_tag_b = 5; cdb_data_b = 32'h55;
    next_cycle();
    chk("t5_pre_count", rob_count, 6);
    flush = 1; alloc_a = 1; alloc_rd_a = 3; cdb_v_a = 1; cdb_tag_a = 6;
    #1;
    chk("t5_wea", wea, 0);
    chk("t5_web", web, 0);
    chk("t5_wlwta", wlwta, 0);
    next_cycle(); #1;
    chk("t5_count", rob_count, 0);
    alloc_a = 1; alloc_rd_a = 2;
    #1 chk("t5_idx", wlwt_ROB_index_a, 1);

    // Forwarding reads (tags 2,3,4 allocated; tag 4 completes)
    next_cycle();
    alloc_a = 1; alloc_rd_a = 8; alloc_b = 1; alloc_rd_b = 9;
    next_cycle();
    alloc_a = 1; alloc_rd_a = 6;
    next_cycle();
    cdb_v_a = 1; cdb_tag_a = 4; cdb_data_a = 32'hA5A5;
    next_cycle();
    fwd_tag_a = 4; fwd_tag_b = 0;
    cdb_v_b = 1; cdb_tag_b = 3; cdb_data_b = 32'h3333;
    #1;
`ifdef ROB_FORWARD_EN
    chk("t6_ready_a", fwd_ready_a, 1);
    chk("t6_data_a", fwd_data_a, 32'hA5A5);
    chk("t6_ready_tag0", fwd_ready_b, 0);
    chk("t6_data_tag0", fwd_data_b, 0);
    fwd_tag_b = 3;
    #1 chk("t6_no_bypass", fwd_ready_b, 0);
`endif

    // Asynchronous reset mid-operation
    next_cycle();
    #2 rst = 1;
    #1;
    chk("t7_async_count", rob_count, 0);
    chk("t7_async_rdy_b", alloc_rdy_b, 1);
    chk("t7_async_wea", wea, 0);
    @(posedge clk);
    #1 rst = 0;

    // Mixed traffic checked by the model only
    for (int c = 0; c < 400; c++) begin
      next_cycle();
      alloc_a    = ($urandom_range(0, 3) != 0);
      alloc_b    = $urandom_range(0, 1);
      alloc_rd_a = 5'($urandom_range(0, 31));
      alloc_rd_b = 5'($urandom_range(0, 31));
      cdb_v_a    = ($urandom_range(0, 3) != 0);
      cdb_v_b    = $urandom_range(0, 1);
      cdb_tag_a  = 4'($urandom_range(0, 15));
      cdb_tag_b  = 4'($urandom_range(0, 15));
      cdb_data_a = $urandom;
      cdb_data_b = $urandom;
      fwd_tag_a  = 4'($urandom_range(0, 15));
      fwd_tag_b  = 4'($urandom_range(0, 15));
      flush      = ($urandom_range(0, 40) == 0);
    end
    repeat (3) next_cycle();
    @(negedge clk);
    #1;
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
